amiga_clk_sequencer: RTL

//  Sits directly downstream of the core PLL. Runs on the 28.375 MHz PLL output.
//  - Qualifies the PLL lock signal and sequences the core reset release.
//  - Derives phase-aligned clock enables from one 3-bit phase counter:
//    7 MHz (two opposite phases), C1/C3 quadrature, CCK and the CIA E-clock.
//  - Every Amiga chipset block consumes these enables instead of extra PLL taps.

---
 rtl/amiga_clk_pkg.sv | 20 ++
 rtl/amiga_clk_sequencer_sync2_ff.sv | 29 ++
 rtl/amiga_clk_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/amiga_clk_pkg.sv
// Shared types and constants for the Amiga clock sequencer.
//   seq_state_t    : sequencer FSM states
//   PH_CLK7/CLK7N  : phase[1:0] values that produce the two 7 MHz strobes
//   ECLK_MAX       : last E-clock count before wrapping to 0
//   ECLK_HI_START  : first E-clock count for which E is high
package amiga_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        ALIGN     = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam logic [1:0] PH_CLK7       = 2'd3;
    localparam logic [1:0] PH_CLK7N      = 2'd1;
    localparam logic [3:0] ECLK_MAX      = 4'd9;
    localparam logic [3:0] ECLK_HI_START = 4'd6;

endpackage

// File: rtl/amiga_clk_sequencer_sync2_ff.sv
// sync2_ff: two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk      : destination clock
//   reset_n  : asynchronous active-low reset, both flops clear to 0
//   d_i      : asynchronous input level
//   q_o      : synchronised level, two clk of latency
module sync2_ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/amiga_clk_sequencer.sv
// amiga_clk_sequencer: qualifies PLL lock, sequences chipset reset release and
// derives phase-aligned clock enables from a free-running 3-bit phase counter.
// Optional E-clock logic is built only when the macro SEQ_ECLK_EN is defined;
// otherwise eclk_o and eclk_en_o are tied low.
// Ports:
//   clk            : 28.375 MHz PLL clock
//   reset_n        : asynchronous active-low reset
//   pll_locked_i   : PLL lock, asynchronous to clk
//   core_reset_n_o : chipset reset, low except in RUN
//   running_o      : high while in RUN
//   phase_o        : phase counter
//   clk7_en_o      : 7 MHz strobe at phase[1:0]==3
//   clk7n_en_o     : 7 MHz strobe at phase[1:0]==1
//   c1_o / c3_o    : 7 MHz quadrature levels
//   cck_o          : colour clock level
//   eclk_o         : CIA E-clock level
//   eclk_en_o      : strobe on the E falling edge
//
// state     | meaning
// WAIT_LOCK | waiting for synchronised lock
// HOLD      | lock must stay high for LOCK_HOLD clk
// ALIGN     | waiting for phase 7 so RUN starts at phase 0
// RUN       | chipset out of reset, enables active
module amiga_clk_sequencer
    import amiga_clk_pkg::*;
#(
    parameter int LOCK_HOLD = 1024,
    parameter int HOLD_W    = 11
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked_i,
    output logic       core_reset_n_o,
    output logic       running_o,
    output logic [2:0] phase_o,
    output logic       clk7_en_o,
    output logic       clk7n_en_o,
    output logic       c1_o,
    output logic       c3_o,
    output logic       cck_o,
    output logic       eclk_o,
    output logic       eclk_en_o
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);

    logic              lk;
    seq_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        phase_q, phase_d;
    logic              run_d;
    logic              running_q;
    logic              clk7_q, clk7n_q, c1_q, c3_q, cck_q;

    sync2_ff u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (pll_locked_i),
        .q_o     (lk)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) state_d = ALIGN;
                else                     hold_d  = hold_q + 1'b1;
            end
            ALIGN: begin
                if (phase_q == 3'd7) state_d = RUN;
            end
            default: ;
        endcase
        // Lock loss overrides every other transition.
        if (state_q != WAIT_LOCK && !lk) state_d = WAIT_LOCK;
    end

    assign phase_d = phase_q + 3'd1;
    assign run_d   = (state_d == RUN);

    // Outputs decode the next phase so they line up with phase_o after the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= WAIT_LOCK;
            hold_q    <= '0;
            phase_q   <= '0;
            running_q <= 1'b0;
            clk7_q    <= 1'b0;
            clk7n_q   <= 1'b0;
            c1_q      <= 1'b0;
            c3_q      <= 1'b0;
            cck_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            phase_q   <= phase_d;
            running_q <= run_d;
            clk7_q    <= run_d && (phase_d[1:0] == PH_CLK7);
            clk7n_q   <= run_d && (phase_d[1:0] == PH_CLK7N);
            c1_q      <= run_d && phase_d[1];
            c3_q      <= run_d && (phase_d[1] ^ phase_d[0]);
            cck_q     <= run_d && phase_d[2];
        end
    end

    assign core_reset_n_o = running_q;
    assign running_o      = running_q;
    assign phase_o        = phase_q;
    assign clk7_en_o      = clk7_q;
    assign clk7n_en_o     = clk7n_q;
    assign c1_o           = c1_q;
    assign c3_o           = c3_q;
    assign cck_o          = cck_q;

`ifdef SEQ_ECLK_EN
    logic [3:0] ecnt_q, ecnt_d;
    logic       tick_d;
    logic       eclk_q, eclk_en_q;

    assign tick_d = run_d && (phase_d[1:0] == PH_CLK7);

    always_comb begin
        ecnt_d = ecnt_q;
        if (!run_d)     ecnt_d = '0;
        else if (tick_d) ecnt_d = (ecnt_q == ECLK_MAX) ? 4'd0 : ecnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ecnt_q    <= '0;
            eclk_q    <= 1'b0;
            eclk_en_q <= 1'b0;
        end else begin
            ecnt_q    <= ecnt_d;
            eclk_q    <= run_d && (ecnt_d >= ECLK_HI_START);
            eclk_en_q <= tick_d && (ecnt_q == ECLK_MAX);
        end
    end

    assign eclk_o    = eclk_q;
    assign eclk_en_o = eclk_en_q;
`else
    assign eclk_o    = 1'b0;
    assign eclk_en_o = 1'b0;
`endif

endmodule
